pipeline_sequencer: RTL and testbench

//  Central stall/flush/halt controller for the 16-bit 5-stage Pipelined_Processor.

---
 rtl/pipeline_sequencer_if.sv | 31 +++
 rtl/pipeline_sequencer.sv | 172 +++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush/halt sequencer.
// The datapath side uses master (drives hazard flags), the sequencer uses slave.
interface pipeline_sequencer_if #(
  parameter int DataWidth = 16
);
  logic                 load_use_hazard;
  logic                 branch_taken_ex;
  logic                 mul_start_ex;
  logic                 halt_id;
  logic                 pc_en;
  logic                 ifid_en;
  logic                 ifid_flush;
  logic                 idex_bubble;
  logic                 ex_hold;
  logic                 exmem_bubble;
  logic                 halted;
  logic [1:0]           state;
  logic [DataWidth-1:0] stall_count;

  modport master (
    output load_use_hazard, branch_taken_ex, mul_start_ex, halt_id,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, exmem_bubble,
    input  halted, state, stall_count
  );

  modport slave (
    input  load_use_hazard, branch_taken_ex, mul_start_ex, halt_id,
    output pc_en, ifid_en, ifid_flush, idex_bubble, ex_hold, exmem_bubble,
    output halted, state, stall_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Stall/flush/halt controller for the 5-stage pipeline: holds EX for multi-cycle ops,
// drains the pipe after HALT and keeps a saturating count of front-end stall cycles.
module pipeline_sequencer #(
  parameter int MulLatency  = 4,
  parameter int DrainCycles = 3,
  parameter int CntBits     = 3,
  parameter int DataWidth   = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  pipeline_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    MUL    = 2'b01,
    DRAIN  = 2'b10,
    HALTED = 2'b11
  } seq_state_t;

  localparam logic              MUL_EN     = (MulLatency > 1);
  localparam logic [CntBits-1:0] MUL_LOAD   = CntBits'((MulLatency > 1) ? (MulLatency - 2) : 0);
  localparam logic [CntBits-1:0] DRAIN_LOAD = CntBits'(DrainCycles - 1);
  localparam logic [CntBits-1:0] CNT_ZERO   = {CntBits{1'b0}};
  localparam logic [CntBits-1:0] CNT_ONE    = CntBits'(32'd1);
  localparam logic [DataWidth-1:0] STALL_MAX = {DataWidth{1'b1}};

  seq_state_t           state_r;
  seq_state_t           state_next_s;
  logic [CntBits-1:0]   cnt_r;
  logic [CntBits-1:0]   cnt_next_s;
  logic [DataWidth-1:0] stall_count_r;

  logic run_eval_s;
  logic allow_mul_s;
  logic pc_en_s;
  logic ifid_en_s;
  logic ifid_flush_s;
  logic idex_bubble_s;
  logic ex_hold_s;
  logic exmem_bubble_s;
  logic halted_s;
  logic stall_inc_s;

  // State, counter and stall-count registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= RUN;
      cnt_r         <= CNT_ZERO;
      stall_count_r <= {DataWidth{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      if (stall_inc_s) begin
        stall_count_r <= stall_count_r + {{(DataWidth-1){1'b0}}, 1'b1};
      end else begin
        stall_count_r <= stall_count_r;
      end
    end
  end

  // Next-state and pipeline control outputs
  always_comb begin
    state_next_s   = state_r;
    cnt_next_s     = cnt_r;
    run_eval_s     = 1'b0;
    allow_mul_s    = 1'b0;
    pc_en_s        = 1'b1;
    ifid_en_s      = 1'b1;
    ifid_flush_s   = 1'b0;
    idex_bubble_s  = 1'b0;
    ex_hold_s      = 1'b0;
    exmem_bubble_s = 1'b0;
    halted_s       = 1'b0;

    case (state_r)
      RUN: begin
        run_eval_s  = 1'b1;
        allow_mul_s = MUL_EN;
      end
      MUL: begin
        if (cnt_r != CNT_ZERO) begin
          pc_en_s        = 1'b0;
          ifid_en_s      = 1'b0;
          ex_hold_s      = 1'b1;
          exmem_bubble_s = 1'b1;
          cnt_next_s     = cnt_r - CNT_ONE;
        end else begin
          // Release cycle: behaves as RUN but may not start another multi-cycle op
          state_next_s = RUN;
          run_eval_s   = 1'b1;
        end
      end
      DRAIN: begin
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        idex_bubble_s = 1'b1;
        if (cnt_r == CNT_ONE) begin
          state_next_s = HALTED;
          cnt_next_s   = CNT_ZERO;
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
        end
      end
      HALTED: begin
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        idex_bubble_s = 1'b1;
        halted_s      = 1'b1;
      end
      default: begin
        state_next_s = RUN;
        cnt_next_s   = CNT_ZERO;
      end
    endcase

    if (run_eval_s) begin
      if (bus.branch_taken_ex) begin
        ifid_flush_s  = 1'b1;
        idex_bubble_s = 1'b1;
      end else if (bus.mul_start_ex && allow_mul_s) begin
        pc_en_s        = 1'b0;
        ifid_en_s      = 1'b0;
        ex_hold_s      = 1'b1;
        exmem_bubble_s = 1'b1;
        cnt_next_s     = MUL_LOAD;
        state_next_s   = MUL;
      end else if (bus.halt_id) begin
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        idex_bubble_s = 1'b1;
        cnt_next_s    = DRAIN_LOAD;
        state_next_s  = DRAIN;
      end else if (bus.load_use_hazard) begin
        pc_en_s       = 1'b0;
        ifid_en_s     = 1'b0;
        idex_bubble_s = 1'b1;
      end else begin
        pc_en_s = 1'b1;
      end
    end else begin
      allow_mul_s = 1'b0;
    end

    stall_inc_s = !pc_en_s && ((state_r == RUN) || (state_r == MUL)) &&
                  (stall_count_r != STALL_MAX);

    // Reset forces the front end empty in the very cycle it is asserted
    if (RST) begin
      pc_en_s        = 1'b0;
      ifid_en_s      = 1'b0;
      ifid_flush_s   = 1'b1;
      idex_bubble_s  = 1'b1;
      ex_hold_s      = 1'b0;
      exmem_bubble_s = 1'b0;
      halted_s       = 1'b0;
    end else begin
      halted_s = halted_s;
    end
  end

  assign bus.pc_en        = pc_en_s;
  assign bus.ifid_en      = ifid_en_s;
  assign bus.ifid_flush   = ifid_flush_s;
  assign bus.idex_bubble  = idex_bubble_s;
  assign bus.ex_hold      = ex_hold_s;
  assign bus.exmem_bubble = exmem_bubble_s;
  assign bus.halted       = halted_s;
  assign bus.state        = state_r;
  assign bus.stall_count  = stall_count_r;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer (MulLatency=4, DrainCycles=3).
module tb_pipeline_sequencer;
  logic CLK;
  logic RST;
  int   checks;
  int   errors;

  pipeline_sequencer_if #(.DataWidth(16)) bus ();

  pipeline_sequencer #(
    .MulLatency (4),
    .DrainCycles(3),
    .CntBits    (3),
    .DataWidth  (16)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic lu, input logic br, input logic mul, input logic halt);
    bus.load_use_hazard = lu;
    bus.branch_taken_ex = br;
    bus.mul_start_ex    = mul;
    bus.halt_id         = halt;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc_en"},   32'(bus.pc_en), 32'd0);
    check({tag, "_ifid_en"}, 32'(bus.ifid_en), 32'd0);
    check({tag, "_flush"},   32'(bus.ifid_flush), 32'd1);
    check({tag, "_bubble"},  32'(bus.idex_bubble), 32'd1);
    check({tag, "_hold"},    32'(bus.ex_hold), 32'd0);
    check({tag, "_halted"},  32'(bus.halted), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held two cycles
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_outputs("rst1");
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_outputs("rst2");
    check("rst_stall_count", 32'(bus.stall_count), 32'd0);
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("run_pc_en", 32'(bus.pc_en), 32'd1);
    check("run_state", 32'(bus.state), 32'd0);
    check("run_flush", 32'(bus.ifid_flush), 32'd0);

    // Load-use: one bubble
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_pc_en", 32'(bus.pc_en), 32'd0);
    check("lu_ifid_en", 32'(bus.ifid_en), 32'd0);
    check("lu_bubble", 32'(bus.idex_bubble), 32'd1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("lu_next_pc_en", 32'(bus.pc_en), 32'd1);
    check("lu_next_bubble", 32'(bus.idex_bubble), 32'd0);
    check("lu_stall_count", 32'(bus.stall_count), 32'd1);

    // Multi-cycle op: stall cycles 0..2, cycle 3 normal; events in MUL ignored
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("mul0_pc_en", 32'(bus.pc_en), 32'd0);
    check("mul0_hold", 32'(bus.ex_hold), 32'd1);
    check("mul0_exmem", 32'(bus.exmem_bubble), 32'd1);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("mul1_state", 32'(bus.state), 32'd1);
    check("mul1_pc_en", 32'(bus.pc_en), 32'd0);
    check("mul1_hold", 32'(bus.ex_hold), 32'd1);
    check("mul1_flush", 32'(bus.ifid_flush), 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("mul2_hold", 32'(bus.ex_hold), 32'd1);
    check("mul2_exmem", 32'(bus.exmem_bubble), 32'd1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("mul3_pc_en", 32'(bus.pc_en), 32'd1);
    check("mul3_hold", 32'(bus.ex_hold), 32'd0);
    check("mul3_stall_count", 32'(bus.stall_count), 32'd4);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("mul4_state", 32'(bus.state), 32'd0);

    // Branch dominates halt and load-use
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("br_pc_en", 32'(bus.pc_en), 32'd1);
    check("br_flush", 32'(bus.ifid_flush), 32'd1);
    check("br_bubble", 32'(bus.idex_bubble), 32'd1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("br_state", 32'(bus.state), 32'd0);
    check("br_halted", 32'(bus.halted), 32'd0);
    check("br_stall_count", 32'(bus.stall_count), 32'd4);

    // Multi-cycle op with HALT waiting in ID: halt taken on release cycle
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    check("mh0_hold", 32'(bus.ex_hold), 32'd1);
    check("mh0_bubble", 32'(bus.idex_bubble), 32'd0);
    for (int c = 1; c <= 2; c++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check("mh_stall_hold", 32'(bus.ex_hold), 32'd1);
      check("mh_stall_state", 32'(bus.state), 32'd1);
    end
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("mh3_hold", 32'(bus.ex_hold), 32'd0);
    check("mh3_bubble", 32'(bus.idex_bubble), 32'd1);
    check("mh3_pc_en", 32'(bus.pc_en), 32'd0);
    for (int c = 4; c <= 5; c++) begin
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("mh_drain_state", 32'(bus.state), 32'd2);
      check("mh_drain_halted", 32'(bus.halted), 32'd0);
    end
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("mh6_halted", 32'(bus.halted), 32'd1);
    check("mh6_state", 32'(bus.state), 32'd3);
    check("mh6_stall_count", 32'(bus.stall_count), 32'd8);

    // Reset out of HALTED
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_outputs("rst3");
    step();
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst3_state", 32'(bus.state), 32'd0);
    check("rst3_count", 32'(bus.stall_count), 32'd0);

    // Plain HALT: drain cycles 1-2, halted from cycle 3, frozen under random inputs
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("h0_pc_en", 32'(bus.pc_en), 32'd0);
    check("h0_bubble", 32'(bus.idex_bubble), 32'd1);
    for (int c = 1; c <= 2; c++) begin
      step();
      drive(1'b1, 1'b1, 1'b1, 1'b1);
      check("h_drain_state", 32'(bus.state), 32'd2);
      check("h_drain_halted", 32'(bus.halted), 32'd0);
      check("h_drain_pc_en", 32'(bus.pc_en), 32'd0);
    end
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("h3_halted", 32'(bus.halted), 32'd1);
    for (int c = 0; c < 20; c++) begin
      step();
      drive(1'($urandom_range(1)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 1'($urandom_range(1)));
      check("hold_halted", 32'(bus.halted), 32'd1);
      check("hold_pc_en", 32'(bus.pc_en), 32'd0);
      check("hold_count", 32'(bus.stall_count), 32'd1);
    end

    // Reset releases the halt
    RST = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check_reset_outputs("rst4");
    step();
    RST = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst4_state", 32'(bus.state), 32'd0);
    check("rst4_halted", 32'(bus.halted), 32'd0);
    check("rst4_pc_en", 32'(bus.pc_en), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
